// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// ------------
// UART receiver (8 data bits, no parity, 1 stop bit, LSB first) feeding a
// first-word-fall-through receive FIFO read by the SoC.
//
// Parameters
//   CLK_DIV    : CLK cycles per UART bit (4..65535)
//   FIFO_DEPTH : receive FIFO entries (power of two, 2..256)
//
// Ports
//   CLK       in   system clock, all state changes on its rising edge
//   resetn    in   asynchronous active-low reset
//   RX        in   asynchronous serial line, idle high
//   rd_en     in   pop strobe, one byte per cycle, ignored while empty
//   err_clr   in   clears the sticky error flags
//   rd_data   out  FIFO head byte (8'h00 while empty)
//   rx_valid  out  FIFO non-empty
//   rx_full   out  FIFO holds FIFO_DEPTH bytes
//   overrun   out  sticky: a received byte was dropped because the FIFO was full
//   frame_err out  sticky: a stop bit was sampled low

module uart_rx_fifo #(
   parameter int CLK_DIV    = 104,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       CLK,
   input  logic       resetn,
   input  logic       RX,
   input  logic       rd_en,
   input  logic       err_clr,
   output logic [7:0] rd_data,
   output logic       rx_valid,
   output logic       rx_full,
   output logic       overrun,
   output logic       frame_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [15:0] HALF_BIT = 16'(CLK_DIV / 2 - 1);
   localparam logic [15:0] FULL_BIT = 16'(CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t      state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic [2:0]  bitIdx_q, bitIdx_d;
   logic [7:0]  shift_q, shift_d;
   logic        rxMeta_q, rxSync_q, rxPrev_q;
   logic [AW:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic        overrun_q, overrun_d;
   logic        frameErr_q, frameErr_d;
   logic [7:0]  mem [FIFO_DEPTH];

   logic timerDone;
   logic push;
   logic stopBad;
   logic fifoEmpty;
   logic fifoFull;
   logic pop;
   logic wrEn;

   // Two-flop synchronizer plus one history flop for falling-edge detection.
   // All three reset high so releasing reset with an idle line never looks
   // like a start bit.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         rxMeta_q <= 1'b1;
         rxSync_q <= 1'b1;
         rxPrev_q <= 1'b1;
      end else begin
         rxMeta_q <= RX;
         rxSync_q <= rxMeta_q;
         rxPrev_q <= rxSync_q;
      end
   end

   // Receiver state, bit timer, bit index and shift register.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         timer_q  <= '0;
         bitIdx_q <= '0;
         shift_q  <= '0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         bitIdx_q <= bitIdx_d;
         shift_q  <= shift_d;
      end
   end

   // Receiver next-state logic. The start bit is checked half a bit after
   // its falling edge, and every later sample is one full bit apart, so all
   // samples land mid-bit. Leaving STOP at mid-stop-bit lets IDLE catch a
   // start bit that follows immediately.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      bitIdx_d  = bitIdx_q;
      shift_d   = shift_q;
      push      = 1'b0;
      stopBad   = 1'b0;
      timerDone = (timer_q == 16'd0);
      case (state_q)
         IDLE: begin
            if (rxPrev_q && !rxSync_q) begin
               timer_d = HALF_BIT;
               state_d = START;
            end
         end
         START: begin
            if (timerDone) begin
               if (!rxSync_q) begin
                  state_d  = DATA;
                  timer_d  = FULL_BIT;
                  bitIdx_d = 3'd0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         DATA: begin
            if (timerDone) begin
               shift_d[bitIdx_q] = rxSync_q;
               timer_d           = FULL_BIT;
               if (bitIdx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bitIdx_d = bitIdx_q + 3'd1;
               end
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         STOP: begin
            if (timerDone) begin
               if (rxSync_q) begin
                  push = 1'b1;
               end else begin
                  stopBad = 1'b1;
               end
               state_d = IDLE;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FIFO control. Pointers carry one extra wrap bit so full and empty are
   // told apart by the MSB. A pop in the same cycle frees the slot a push
   // into a full FIFO needs, so that push is accepted rather than dropped.
   always_comb begin
      fifoEmpty  = (wrPtr_q == rdPtr_q);
      fifoFull   = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                   (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
      pop        = rd_en && !fifoEmpty;
      wrEn       = push && (!fifoFull || pop);
      wrPtr_d    = wrPtr_q + (wrEn ? (AW+1)'(1) : (AW+1)'(0));
      rdPtr_d    = rdPtr_q + (pop ? (AW+1)'(1) : (AW+1)'(0));
      overrun_d  = (push && fifoFull && !pop) || (overrun_q && !err_clr);
      frameErr_d = stopBad || (frameErr_q && !err_clr);
   end

   // FIFO pointers and sticky error flags; a new error beats err_clr.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         overrun_q  <= 1'b0;
         frameErr_q <= 1'b0;
      end else begin
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         overrun_q  <= overrun_d;
         frameErr_q <= frameErr_d;
      end
   end

   // Storage array. Contents need no reset because an entry is only visible
   // once the write pointer has moved past it.
   always_ff @(posedge CLK) begin
      if (wrEn) begin
         mem[wrPtr_q[AW-1:0]] <= shift_q;
      end
   end

   // Head byte is forced to zero while empty so reset leaves rd_data clear.
   always_comb begin
      rd_data   = fifoEmpty ? 8'h00 : mem[rdPtr_q[AW-1:0]];
      rx_valid  = !fifoEmpty;
      rx_full   = fifoFull;
      overrun   = overrun_q;
      frame_err = frameErr_q;
   end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_DIV, default 104, meaning CLK cycles per UART bit (12 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning receive FIFO entries; power of two, 2..256.
REQ-003 SHALL have port CLK, input, 1, sole system clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port RX, input, 1, asynchronous serial line from pin; idle high.
REQ-006 SHALL have port rd_en, input, 1, SoC pop strobe, one byte per cycle.
REQ-007 SHALL have port err_clr, input, 1, clears sticky error flags.
REQ-008 SHALL have port rd_data, output, 8, FIFO head byte (first-word fall-through).
REQ-009 SHALL have port rx_valid, output, 1, FIFO non-empty.
REQ-010 SHALL have port rx_full, output, 1, FIFO holds FIFO_DEPTH bytes.
REQ-011 SHALL have port overrun, output, 1, sticky: byte dropped because FIFO full.
REQ-012 SHALL have port frame_err, output, 1, sticky: stop bit sampled low.

Function
REQ-013 SHALL pass RX through a two-flop synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-014 SHALL implement a state machine with states IDLE, START, DATA, STOP, plus a bit-timer counter and 3-bit bit index.
REQ-015 IDLE: on a synchronized high-to-low transition, SHALL load timer with CLK_DIV/2 - 1 and enter START.
REQ-016 START: at timer expiry SHALL sample RX; if low, go to DATA with timer CLK_DIV-1 and bit index 0; if high (glitch), return to IDLE with no FIFO write and no error.
REQ-017 DATA: at each timer expiry SHALL shift the sample into bit[index] (LSB first), reload CLK_DIV-1; after index 7 go to STOP.
REQ-018 STOP: at timer expiry SHALL sample RX; high = valid frame, push byte; low = discard byte, set frame_err; either way return to IDLE the same cycle.
REQ-019 Return to IDLE at mid-stop-bit SHALL allow a back-to-back start bit to be detected with no lost frame.
REQ-020 A pushed byte SHALL appear on rd_data with rx_valid high in the cycle after the stop-bit sample.
REQ-021 rd_en with rx_valid high SHALL pop the head; rd_data shows the next entry the following cycle; rd_en while empty SHALL be ignored.
REQ-022 Push and pop in the same cycle SHALL both take effect, including when full (byte accepted, occupancy unchanged) and when empty-then-push (not popped).
REQ-023 Push when full with no pop SHALL drop the new byte, leave FIFO contents unchanged, set overrun.
REQ-024 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits, wrap modulo 2*FIFO_DEPTH; full/empty from pointer MSB compare.
REQ-025 err_clr SHALL clear overrun and frame_err next cycle; a same-cycle new error SHALL win (flag stays set).

Reset
REQ-026 resetn low SHALL immediately clear: state IDLE, timer 0, index 0, FIFO pointers 0, rx_valid 0, rx_full 0, overrun 0, frame_err 0, rd_data 8'h00.
REQ-027 Synchronizer flops SHALL reset to 1 so release of reset with RX idle causes no false start.
REQ-028 resetn asserted mid-frame SHALL abort the frame with no partial byte stored; reception resumes on the next falling edge after release.

Verification (CLK_DIV=8, FIFO_DEPTH=4)
REQ-029 Send 8'hA5 with valid stop -> rx_valid rises 1 cycle after stop sample, rd_data=8'hA5; rd_en pulse -> rx_valid 0.
REQ-030 RX low for 2 cycles then high -> no push, frame_err 0, FSM back in IDLE.
REQ-031 Send 8'h3C with stop bit low -> no push, frame_err 1; err_clr pulse -> frame_err 0.
REQ-032 Send 5 frames 8'h01..8'h05 back-to-back, no reads -> rx_full after 4th, overrun 1, reads return 01,02,03,04 then rx_valid 0.
REQ-033 FIFO full, rd_en asserted in cycle of 5th push -> no overrun, reads return 02,03,04,05.
REQ-034 resetn pulsed low during bit 4 of 8'hFF -> all outputs zero, nothing stored; next frame 8'h5A received correctly.
